data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Data-memory responder for the processor's data-memory port: samples CEN/WEN/OEN/A/Data2Mem
//  and returns ReadDataMem. Holds a DEPTH x DATA_W word array and clears it after reset.
//  Keeps saturating read/write access counters and a sticky protocol-error flag for debug.
//  Sits between the core's data-memory outputs and the testbench/top-level memory slot.
// PARAMETERS
//  ADDR_W          7    word-address width (matches A)
//  DATA_W          32   data word width
//  DEPTH           128  number of words, must equal 2**ADDR_W
//  CNT_W           16   width of rd_count / wr_count
//  CLEAR_ON_RESET  1    1: zero the array after reset; 0: skip the clear phase
// PORTS
//  clk          in   1       single clock; all state updates on posedge
//  rst_n        in   1       synchronous reset, active-high (rst_n=1 resets on the next posedge)
//  CEN          in   1       chip enable, active-low; 1 = no access this cycle
//  WEN          in   1       write enable, active-low
//  OEN          in   1       output (read) enable, active-low
//  A            in   ADDR_W  word address
//  Data2Mem     in   DATA_W  write data
//  ReadDataMem  out  DATA_W  registered read data
//  ready        out  1       1 = clear phase done, accesses are serviced
//  err          out  1       sticky: read and write strobed in the same cycle
//  rd_count     out  CNT_W   serviced reads, saturating
//  wr_count     out  CNT_W   serviced writes, saturating
// BEHAVIOUR
//  Reset (rst_n=1 at posedge)
//   - ReadDataMem=0, ready=0, err=0, rd_count=0, wr_count=0.
//   - clear pointer=0; state=CLEAR, or SERVE if CLEAR_ON_RESET=0.
//   - Array contents are not reset directly.
//  FSM: CLEAR -> SERVE.
//   - CLEAR: writes 0 to mem[ptr] each cycle, ptr++. After the write to ptr=DEPTH-1, moves to SERVE.
//   - CLEAR lasts exactly DEPTH cycles; ready goes to 1 on the edge entering SERVE.
//   - Port strobes are ignored in CLEAR: no access, no count, no err, ReadDataMem holds 0.
//   - SERVE is terminal until reset.
//   - Reset during CLEAR restarts CLEAR from ptr=0.
//  SERVE, at posedge with CEN=0:
//   - Read  (OEN=0, WEN=1): ReadDataMem <= mem[A]. One-cycle latency; value holds until the next read.
//     rd_count++.
//   - Write (WEN=0, OEN=1): mem[A] <= Data2Mem. wr_count++. ReadDataMem unchanged.
//   - Both  (WEN=0, OEN=0): write performed, write-first; ReadDataMem <= Data2Mem.
//     Both counters increment; err <= 1.
//   - Neither (WEN=1, OEN=1): no access, no count.
//  CEN=1: no access regardless of WEN/OEN; no count, no err.
//  Read the cycle after a write to the same A returns the new data (array written at the earlier edge).
//  Counters saturate at 2**CNT_W-1 and never wrap. err clears only on reset.
//  Addresses are full-range (A < DEPTH always); no out-of-range case exists.
// TESTING
//  1. Reset 1 cycle, release -> ready=0 for 128 cycles, then 1; reads of A=0,64,127 -> 0.
//  2. Write A=5 D=32'hDEADBEEF, next cycle read A=5 -> ReadDataMem=32'hDEADBEEF one cycle later;
//     wr_count=1, rd_count=1.
//  3. CEN=1 with WEN=0, A=5, D=0 -> mem[5] unchanged (later read returns DEADBEEF); counters unchanged.
//  4. CEN=0, WEN=0, OEN=0, A=9, D=32'h1234 -> ReadDataMem=32'h1234, err=1;
//     err stays 1 after 10 idle cycles.
//  5. Strobe reads during CLEAR (cycle 50) -> no count, ReadDataMem=0;
//     assert reset at cycle 60 -> ready stays 0 for a fresh 128 cycles.
//  6. CNT_W=4: 20 writes -> wr_count=15 (saturated); rd_count=0.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder: a word array that is zeroed after reset and then services
// CEN/WEN/OEN strobes, with saturating access counters and a sticky read+write error flag.
module data_mem_responder #(
  parameter int ADDR_W         = 7,
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 128,
  parameter int CNT_W          = 16,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              CEN,
  input  logic              WEN,
  input  logic              OEN,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] Data2Mem,
  output logic [DATA_W-1:0] ReadDataMem,
  output logic              ready,
  output logic              err,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count
);

  typedef enum logic [0:0] {CLEAR = 1'b0, SERVE = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  state_t              state_r, state_nxt_s;
  logic [ADDR_W-1:0]   ptr_r;
  logic [DATA_W-1:0]   mem_r [DEPTH];
  logic [DATA_W-1:0]   rdata_r;
  logic                ready_r;
  logic                err_r;
  logic [CNT_W-1:0]    rd_cnt_r;
  logic [CNT_W-1:0]    wr_cnt_r;
  logic                rd_s;
  logic                wr_s;
  logic                mem_we_s;
  logic [ADDR_W-1:0]   mem_addr_s;
  logic [DATA_W-1:0]   mem_wdata_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_W'(1);
    end
  endfunction

  // Next-state and access decode; strobes are only honoured once the clear has finished
  always_comb begin
    state_nxt_s = state_r;
    rd_s        = 1'b0;
    wr_s        = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = A;
    mem_wdata_s = Data2Mem;
    case (state_r)
      CLEAR: begin
        mem_we_s    = 1'b1;
        mem_addr_s  = ptr_r;
        mem_wdata_s = {DATA_W{1'b0}};
        if (ptr_r == LAST_PTR) begin
          state_nxt_s = SERVE;
        end else begin
          state_nxt_s = CLEAR;
        end
      end
      SERVE: begin
        state_nxt_s = SERVE;
        if (CEN == 1'b0) begin
          rd_s = ~OEN;
          wr_s = ~WEN;
        end else begin
          rd_s = 1'b0;
          wr_s = 1'b0;
        end
        mem_we_s = wr_s;
      end
      default: begin
        state_nxt_s = CLEAR;
      end
    endcase
  end

  // State, clear pointer, read data, counters and error flag
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_r  <= (CLEAR_ON_RESET != 0) ? CLEAR : SERVE;
      ptr_r    <= {ADDR_W{1'b0}};
      rdata_r  <= {DATA_W{1'b0}};
      ready_r  <= 1'b0;
      err_r    <= 1'b0;
      rd_cnt_r <= {CNT_W{1'b0}};
      wr_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (state_r == CLEAR) begin
        ptr_r <= ptr_r + ADDR_W'(1);
      end
      ready_r <= (state_nxt_s == SERVE);
      // Simultaneous read and write returns the incoming data (write-first)
      if (rd_s && wr_s) begin
        rdata_r <= Data2Mem;
      end else if (rd_s) begin
        rdata_r <= mem_r[A];
      end
      if (rd_s) begin
        rd_cnt_r <= sat_inc(rd_cnt_r);
      end
      if (wr_s) begin
        wr_cnt_r <= sat_inc(wr_cnt_r);
      end
      if (rd_s && wr_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // Array storage has no reset; the CLEAR phase zeroes it instead
  always_ff @(posedge clk) begin
    if (mem_we_s && !rst_n) begin
      mem_r[mem_addr_s] <= mem_wdata_s;
    end
  end

  assign ReadDataMem = rdata_r;
  assign ready       = ready_r;
  assign err         = err_r;
  assign rd_count    = rd_cnt_r;
  assign wr_count    = wr_cnt_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: read expectations are queued by the stimulus
// and checked by an independent monitor; status outputs are checked directly.
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic        cen, wen, oen;
  logic [6:0]  a;
  logic [31:0] d;
  logic [31:0] rdata;
  logic        ready, err;
  logic [15:0] rd_count, wr_count;

  logic        cen2, wen2, oen2;
  logic [6:0]  a2;
  logic [31:0] d2;
  logic [31:0] rdata2;
  logic        ready2, err2;
  logic [3:0]  rd_count2, wr_count2;

  int          compared;
  int          mismatched;
  logic        rd_fire;
  logic [31:0] exp_q[$];

  data_mem_responder dut (
    .clk(clk), .rst_n(rst), .CEN(cen), .WEN(wen), .OEN(oen), .A(a), .Data2Mem(d),
    .ReadDataMem(rdata), .ready(ready), .err(err), .rd_count(rd_count), .wr_count(wr_count)
  );

  data_mem_responder #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst), .CEN(cen2), .WEN(wen2), .OEN(oen2), .A(a2), .Data2Mem(d2),
    .ReadDataMem(rdata2), .ready(ready2), .err(err2), .rd_count(rd_count2), .wr_count(wr_count2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One posedge with the given strobes, then back to idle
  task automatic step(input logic c, input logic w, input logic o,
                      input logic [6:0] addr, input logic [31:0] data, input logic fire);
    cen = c; wen = w; oen = o; a = addr; d = data; rd_fire = fire;
    @(negedge clk);
    cen = 1'b1; wen = 1'b1; oen = 1'b1; rd_fire = 1'b0;
  endtask

  task automatic do_read(input logic [6:0] addr, input logic [31:0 ] exp);
    exp_q.push_back(exp);
    step(1'b0, 1'b1, 1'b0, addr, 32'h0, 1'b1);
  endtask

  task automatic do_write(input logic [6:0] addr, input logic [31:0] data);
    step(1'b0, 1'b0, 1'b1, addr, data, 1'b0);
  endtask

  // Monitor: a read issued at a posedge is checked against the queue on the following negedge
  initial begin
    logic        f;
    logic [31:0] e;
    forever begin
      @(posedge clk);
      f = rd_fire;
      @(negedge clk);
      if (f) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL rd_unexpected: got %h expected none", rdata);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", rdata, e);
        end
      end
    end
  end

  initial begin
    compared = 0; mismatched = 0; rd_fire = 1'b0;
    cen = 1'b1; wen = 1'b1; oen = 1'b1; a = 7'd0; d = 32'd0;
    cen2 = 1'b1; wen2 = 1'b1; oen2 = 1'b1; a2 = 7'd0; d2 = 32'd0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rd_count", {16'd0, rd_count}, 32'd0);
    chk("rst_wr_count", {16'd0, wr_count}, 32'd0);
    rst = 1'b0;

    // Strobes during CLEAR are ignored; reset at cycle 60 restarts the clear
    for (int i = 0; i < 60; i++) begin
      if (i == 49) begin
        step(1'b0, 1'b0, 1'b0, 7'd3, 32'hFFFF_FFFF, 1'b0);
      end else if (i == 50) begin
        step(1'b0, 1'b1, 1'b0, 7'd3, 32'd0, 1'b0);
      end else begin
        @(negedge clk);
      end
      chk("clear1_ready", {31'd0, ready}, 32'd0);
    end
    chk("clear_rd_count", {16'd0, rd_count}, 32'd0);
    chk("clear_wr_count", {16'd0, wr_count}, 32'd0);
    chk("clear_err", {31'd0, err}, 32'd0);
    chk("clear_rdata", rdata, 32'd0);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      chk("clear2_ready", {31'd0, ready}, (i == 127) ? 32'd1 : 32'd0);
    end
    chk("ready_sat", {31'd0, ready2}, 32'd1);

    do_read(7'd0, 32'd0);
    do_read(7'd64, 32'd0);
    do_read(7'd127, 32'd0);

    do_write(7'd5, 32'hDEAD_BEEF);
    do_read(7'd5, 32'hDEAD_BEEF);
    chk("t2_wr_count", {16'd0, wr_count}, 32'd1);
    chk("t2_rd_count", {16'd0, rd_count}, 32'd4);

    step(1'b1, 1'b0, 1'b1, 7'd5, 32'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 7'd5, 32'd0, 1'b0);
    chk("t3_wr_count", {16'd0, wr_count}, 32'd1);
    chk("t3_rd_count", {16'd0, rd_count}, 32'd4);
    do_read(7'd5, 32'hDEAD_BEEF);
    chk("t3_err", {31'd0, err}, 32'd0);

    exp_q.push_back(32'h0000_1234);
    step(1'b0, 1'b0, 1'b0, 7'd9, 32'h0000_1234, 1'b1);
    chk("t4_err", {31'd0, err}, 32'd1);
    chk("t4_wr_count", {16'd0, wr_count}, 32'd2);
    chk("t4_rd_count", {16'd0, rd_count}, 32'd6);
    repeat (10) @(negedge clk);
    chk("t4_err_sticky", {31'd0, err}, 32'd1);
    do_read(7'd9, 32'h0000_1234);
    do_write(7'd30, 32'h5555_0000);
    chk("rdata_hold", rdata, 32'h0000_1234);
    do_write(7'd20, 32'hAAAA_5555);
    do_read(7'd20, 32'hAAAA_5555);
    do_read(7'd30, 32'h5555_0000);
    chk("end_wr_count", {16'd0, wr_count}, 32'd4);
    chk("end_rd_count", {16'd0, rd_count}, 32'd9);

    // Saturating 4-bit counter instance
    for (int i = 0; i < 20; i++) begin
      cen2 = 1'b0; wen2 = 1'b0; oen2 = 1'b1; a2 = 7'(i); d2 = 32'(i);
      @(negedge clk);
      if (i == 14) begin
        chk("sat_wr_at15", {28'd0, wr_count2}, 32'd15);
      end
    end
    cen2 = 1'b1; wen2 = 1'b1;
    @(negedge clk);
    chk("sat_wr_count", {28'd0, wr_count2}, 32'd15);
    chk("sat_rd_count", {28'd0, rd_count2}, 32'd0);

    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
